// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus seen by the UART transmitter: the processor side is the master,
// the UART register window is the slave.
interface mmio_uart_tx_if;
  // A write commits at the rising edge where we = 1 and hit = 1; there is no
  // stall. Reads are combinational from current state with no wait states, and
  // rdata is 0 whenever hit = 0 so it can be OR-ed or muxed with dmem.
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  hit
  );

  modport slave (
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output hit
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, sitting beside dmem.
// Registers: 0x0 TXDATA, 0x4 STATUS, 0x8 CTRL, 0xC reserved.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           irq,
  output logic [1:0]     state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          overflow;
  logic          irq_en;
  logic          irq_en_nxt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sr;

  logic [1:0]    reg_sel;
  logic          sel_wr;
  logic          push_req;
  logic          ovf_clr;
  logic          ctrl_wr;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic          baud_last;
  logic          idle_nxt;
  logic [4:0]    count_ext;
  logic          unused_bits;

  // Bus decode; addr[1:0] and the upper write-data bits carry no meaning here.
  assign bus.hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel     = bus.addr[3:2];
  assign sel_wr      = bus.we & bus.hit;
  assign push_req    = sel_wr && (reg_sel == 2'd0);
  assign ovf_clr     = sel_wr && (reg_sel == 2'd1) && bus.wdata[3];
  assign ctrl_wr     = sel_wr && (reg_sel == 2'd2);
  assign unused_bits = &{1'b0, bus.wdata[31:8], bus.addr[1:0]};

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign pop       = (state == IDLE) && !empty;
  // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push_req && (!full || pop);
  assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign state_dbg = state;

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push_ok && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  assign irq_en_nxt = ctrl_wr ? bus.wdata[0] : irq_en;
  assign idle_nxt   = ((state == IDLE) && !pop) || ((state == STOP) && baud_last);

  // FIFO storage is not reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus.wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nxt;
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      irq_en <= irq_en_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      irq      <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      sr       <= 8'd0;
    end else begin
      irq <= idle_nxt && (count_nxt == '0) && irq_en_nxt;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            sr       <= fifo_mem[rd_ptr];
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_last) begin
            tx       <= sr[0];
            bit_idx  <= 3'd0;
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            sr       <= {1'b0, sr[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            // sr[1] becomes sr[0] after this shift, so it is the next bit out.
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx <= sr[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  assign count_ext = 5'(count);

  always_comb begin
    bus.rdata = 32'd0;
    if (bus.hit) begin
      case (reg_sel)
        2'd1:    bus.rdata = {23'd0, count_ext, overflow, empty, full, (state != IDLE)};
        2'd2:    bus.rdata = {31'd0, irq_en};
        default: bus.rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-level reference model feeds an expected-frame
// queue, and a serial monitor decodes tx and compares every frame it sees.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE   = 32'hFFFF_0000;
  localparam int          CPB    = 4;
  localparam int          DEPTH  = 4;
  localparam int          FW     = 10 * CPB;
  localparam int          PERIOD = 10 * CPB + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx;
  logic       irq;
  logic [1:0] state_dbg;

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .tx        (tx),
    .irq       (irq),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  started = 1'b0;

  // Reference model: bytes waiting in the FIFO, edge at which the next pop is allowed.
  logic [7:0]  m_q[$];
  int          idle_at = 0;
  bit          m_ovf = 1'b0;
  bit          m_irq_en = 1'b0;
  bit          m_irq = 1'b0;
  logic [39:0] exp_q[$];  // {start edge, byte}
  int          last_gap = 0;
  int          prev_start = -1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_busy();
    return cyc < idle_at - 1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd1: return {23'd0, 5'(m_q.size()), m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH), m_busy()};
      2'd2: return {31'd0, m_irq_en};
      default: return 32'd0;
    endcase
  endfunction

  // Model: one frame = 10 bit times, plus one idle edge before the next pop.
  initial begin : model
    bit         sel;
    bit         push;
    bit         pop;
    bit         acc;
    logic [1:0] rs;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        m_q.delete();
        exp_q.delete();
        idle_at  = cyc + 1;
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
        m_irq    = 1'b0;
      end else begin
        sel  = bus_if.we && (bus_if.addr[31:4] == BASE[31:4]);
        rs   = bus_if.addr[3:2];
        pop  = (cyc >= idle_at) && (m_q.size() > 0);
        push = sel && (rs == 2'd0);
        acc  = push && ((m_q.size() < DEPTH) || pop);
        if (push && !acc) m_ovf = 1'b1;
        if (sel && (rs == 2'd1) && bus_if.wdata[3]) m_ovf = 1'b0;
        if (sel && (rs == 2'd2)) m_irq_en = bus_if.wdata[0];
        if (pop) begin
          exp_q.push_back({cyc[31:0], m_q.pop_front()});
          idle_at = cyc + PERIOD;
        end
        if (acc) m_q.push_back(bus_if.wdata[7:0]);
        m_irq = !m_busy() && (m_q.size() == 0) && m_irq_en;
      end
    end
  end

  // Serial monitor: samples every cycle of a frame and compares the whole waveform.
  initial begin : monitor
    logic [FW-1:0] obs;
    logic [FW-1:0] expw;
    logic [39:0]   e;
    int            st;
    bit            aborted;
    bit            v;
    forever begin
      @(negedge clk);
      if (started && !reset && (tx === 1'b0)) begin
        st      = cyc;
        obs     = '0;
        obs[0]  = tx;
        aborted = 1'b0;
        for (int n = 1; n < FW; n++) begin
          @(negedge clk);
          if (reset) aborted = 1'b1;
          obs[n] = tx;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got frame %0h at edge %0d expected no frame", obs, st);
          end else begin
            e = exp_q.pop_front();
            for (int s = 0; s < 10; s++) begin
              v = (s == 0) ? 1'b0 : ((s == 9) ? 1'b1 : e[s-1]);
              for (int j = 0; j < CPB; j++) expw[s*CPB+j] = v;
            end
            chk("frame_bits", obs, expw);
            chk("frame_start", st, e[39:8]);
            last_gap   = st - prev_start;
            prev_start = st;
          end
        end
      end
    end
  end

  initial begin : irq_mon
    forever begin
      @(negedge clk);
      if (started) begin
        chk("irq", irq, m_irq);
        chk("busy_dbg", state_dbg != 2'd0, m_busy());
      end
    end
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.we    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(negedge clk);
    bus_if.we = 1'b0;
  endtask

  task automatic read_chk(input logic [31:0] a, input string name);
    bus_if.we   = 1'b0;
    bus_if.addr = a;
    #1;
    chk(name, bus_if.rdata, exp_read(a));
    chk({name, "_hit"}, bus_if.hit, a[31:4] == BASE[31:4]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (((m_q.size() != 0) || (exp_q.size() != 0) || m_busy()) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d frames outstanding after %0d cycles expected 0", name, exp_q.size(), n);
    end
  endtask

  task automatic pulse_reset();
    reset     = 1'b1;
    bus_if.we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : driver
    int          op;
    logic [31:0] a;
    bus_if.we    = 1'b0;
    bus_if.addr  = 32'd0;
    bus_if.wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    started = 1'b1;

    // Reset state
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_irq", irq, 1'b0);
    read_chk(BASE + 32'h4, "rst_status");
    chk("rst_status_val", bus_if.rdata, 32'h4);
    @(negedge clk);

    // Single frame 0xA5
    bus_write(BASE, 32'h0000_00A5);
    repeat (6) @(negedge clk);
    read_chk(BASE + 32'h4, "t1_status_busy");
    chk("t1_busy_bit", bus_if.rdata[0], 1'b1);
    wait_drain("t1_drain");
    read_chk(BASE + 32'h4, "t1_status_idle");
    chk("t1_status_val", bus_if.rdata, 32'h4);

    // Five accepted pushes, sixth dropped into a full FIFO
    for (int i = 0; i < 6; i++) bus_write(BASE, 32'h11 + i);
    read_chk(BASE + 32'h4, "t2_status_ovf");
    chk("t2_ovf_bit", bus_if.rdata[3], 1'b1);
    chk("t2_count", bus_if.rdata[8:4], 5'd4);
    bus_write(BASE + 32'h4, 32'h8);
    read_chk(BASE + 32'h4, "t2_status_clr");
    chk("t2_ovf_clr", bus_if.rdata[3], 1'b0);
    wait_drain("t2_drain");

    // irq around a frame
    bus_write(BASE + 32'h8, 32'h1);
    chk("t3_irq_idle", irq, 1'b1);
    bus_write(BASE, 32'h3C);
    chk("t3_irq_push", irq, 1'b0);
    repeat (20) @(negedge clk);
    chk("t3_irq_mid", irq, 1'b0);
    wait_drain("t3_drain");
    chk("t3_irq_after", irq, 1'b1);
    bus_write(BASE + 32'h8, 32'h0);
    chk("t3_irq_off", irq, 1'b0);

    // Reset mid-DATA with two bytes queued
    bus_write(BASE, 32'h5A);
    bus_write(BASE, 32'h01);
    bus_write(BASE, 32'h02);
    repeat (6) @(negedge clk);
    pulse_reset();
    chk("t4_tx_high", tx, 1'b1);
    read_chk(BASE + 32'h4, "t4_status");
    chk("t4_status_val", bus_if.rdata, 32'h4);
    repeat (60) @(negedge clk);
    chk("t4_tx_quiet", tx, 1'b1);

    // Reserved and out-of-window accesses
    read_chk(BASE + 32'hC, "t5_rsvd");
    chk("t5_rsvd_val", bus_if.rdata, 32'd0);
    chk("t5_rsvd_hitv", bus_if.hit, 1'b1);
    read_chk(32'h0000_0010, "t5_out");
    chk("t5_out_hitv", bus_if.hit, 1'b0);
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
    bus_write(32'h0000_0010, 32'hFFFF_FFFF);
    bus_write(32'h0000_0000, 32'h55);
    bus_write(32'h0000_0008, 32'h1);
    read_chk(BASE + 32'h4, "t5_status");
    chk("t5_status_val", bus_if.rdata, 32'h4);
    read_chk(BASE + 32'h8, "t5_ctrl");
    repeat (20) @(negedge clk);

    // Back-to-back frames
    bus_write(BASE, 32'hFF);
    bus_write(BASE, 32'h00);
    wait_drain("t6_drain");
    chk("t6_period", last_gap, PERIOD);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        bus_write(BASE | 32'($urandom_range(0, 3)), $urandom());
      end else if (op == 6) begin
        bus_write(BASE + 32'h4, $urandom());
      end else if (op == 7) begin
        bus_write(BASE + 32'h8 + 32'($urandom_range(0, 3)), $urandom());
      end else if (op == 8) begin
        a = (op[0] == 1'b0 && $urandom_range(0, 1) == 0) ? (BASE + 32'hC) : 32'($urandom_range(0, 32'h7FFF_FFFF));
        bus_write(a, $urandom());
      end else begin
        read_chk(BASE | 32'($urandom_range(0, 15)), "rand_read");
      end
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_drain("rand_drain");
    chk("end_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the MIPS data-memory bus (dmem_we / dmem_addr / dmem_wdata / dmem_rdata), alongside dmem.
- The processor stores bytes into a small TX FIFO.
- The block serializes them 8N1, LSB first, on a registered serial line.
- A status register is readable with the same combinational-read timing as dmem.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base of the 16-byte register window; must be 16-byte aligned.
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range is 2 or more.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, from 2 to 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- we  input  1  bus write enable (dmem_we).
- addr  input  32  bus byte address (dmem_addr).
- wdata  input  32  bus write data (dmem_wdata).
- rdata  output  32  combinational read data; 0 when not selected.
- hit  output  1  combinational; 1 when addr[31:4] == BASE_ADDR[31:4]. Used by the top-level read mux and to suppress the dmem write.
- tx  output  1  registered serial output; idle high.
- irq  output  1  registered; 1 when the FIFO is empty, the FSM is IDLE, and irq_en = 1.

Behaviour:
- Register map, selected by addr[3:2] when hit = 1:
  - 0x0 TXDATA. Write pushes wdata[7:0]. Read returns 0.
  - 0x4 STATUS (read): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[8:4] count (0..FIFO_DEPTH), all other bits 0. Writing with wdata[3] = 1 clears overflow; all other written bits are ignored.
  - 0x8 CTRL: bit0 irq_en (reset 0). Read returns {31'b0, irq_en}.
  - 0xC reserved: reads return 0, writes are ignored.
- Access rules: addr[1:0] is ignored, and only full-word accesses are defined. A write takes effect at the rising edge where we = 1 and hit = 1. Reads are combinational from current state, with no wait states.
- Reset, at the first edge with reset = 1:
  - tx = 1, irq = 0.
  - FIFO empty (pointers = 0, count = 0), overflow = 0, irq_en = 0.
  - FSM = IDLE, baud counter = 0, bit index = 0.
  - Reset mid-frame aborts the frame immediately: tx is high after that edge, and FIFO contents are discarded.
- FIFO:
  - Circular buffer with write/read pointers of width log2(FIFO_DEPTH) that wrap modulo FIFO_DEPTH, plus a count register of width log2(FIFO_DEPTH)+1.
  - A push while full and no pop in the same cycle is dropped and sets overflow.
  - A push and a pop in the same edge are both performed; count is unchanged. This holds even when full: the push is accepted and overflow is not set.
  - A pop occurs only in the FSM IDLE→START transition.
- FSM, with a baud counter (0..CLKS_PER_BIT-1) and a bit index (0..7):
  - IDLE: tx = 1. If the FIFO is non-empty (count before the edge > 0), pop into shift register sr, drive tx = 0, clear the baud counter, go to START. A byte pushed at edge k is therefore popped at edge k+1, and tx falls at edge k+1.
  - START: hold tx = 0 for CLKS_PER_BIT cycles. On the last cycle, tx = sr[0], bit index = 0, go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. At the end of each bit: shift sr right and increment the bit index; after bit 7, drive tx = 1 and go to STOP.
  - STOP: hold tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
  - IDLE to the next pop takes one edge. Back-to-back frames therefore have exactly 1 extra idle cycle, and frame period = 10*CLKS_PER_BIT + 1 cycles.
- Bus writes during transmission do not disturb the frame in flight.
- irq: registered from next-state values; it asserts on the edge where STOP→IDLE occurs with the FIFO empty and irq_en = 1.

Test Plan:
1. CLKS_PER_BIT = 4. After reset, write 0x000000A5 to 0xFFFF0000 at edge k → tx low from edge k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. STATUS reads busy = 1 during the frame and 0x004 (empty) after it.
2. Write five bytes 0x11..0x15 on consecutive cycles with FIFO_DEPTH = 4 → first pop frees a slot, so all 5 are accepted with no overflow. Sixth write, issued while count = 4 and no pop → dropped; STATUS bit3 = 1. Write STATUS with 0x8 → bit3 = 0.
3. Set CTRL = 1, send 0x3C → irq = 0 during the frame and 1 after STOP completes. Write CTRL = 0 → irq = 0 at the next edge.
4. Assert reset mid-DATA of byte 0x5A with 2 bytes queued → tx = 1, STATUS = 0x004, no further frames.
5. Access 0xFFFF000C and 0x00000010 → reads return 0, hit = 1/0 respectively, writes have no effect. A write to 0x00000000 does not push.
6. Two queued bytes 0xFF, 0x00 → frames separated by exactly 1 idle-high cycle; total period 41 cycles at CLKS_PER_BIT = 4.
